// File: rtl/gmii_tx_preamble_ifg.sv
// GMII transmit framer: prefixes FCS-complete frames with preamble/SFD through a fixed-latency
// delay line, enforces a minimum output inter-frame gap and drops frames that start too early.
//
// state | meaning
// IDLE  | line idle, ready to accept a new start of frame
// PRE   | emitting 0x55 preamble bytes, then the 0xD5 SFD
// DATA  | forwarding delay-line bytes while their keep flag is set
// GAP   | holding the line idle to complete the inter-frame gap
module gmii_tx_preamble_ifg #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_BYTES    = 12,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gmii_dv_in,
  input  logic [7:0]       gmii_data_in,
  output logic             gmii_tx_en,
  output logic [7:0]       gmii_txd,
  output logic             drop_pulse,
  output logic [CNT_W-1:0] frames_sent,
  output logic [CNT_W-1:0] frames_dropped
);

  localparam int         DEPTH    = PREAMBLE_LEN + 1;
  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);
  localparam logic [7:0] GAP_LAST = 8'(IFG_BYTES - 1);

  typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;

  state_t     state;
  logic       dv_prev;
  logic       in_frame;
  logic [3:0] pre_cnt;
  logic [7:0] gap_cnt;
  logic [8:0] dline [DEPTH];

  logic sof;
  logic accept;
  logic keep_in;

  assign sof     = gmii_dv_in & ~dv_prev;
  assign accept  = sof & (state == IDLE);
  assign keep_in = gmii_dv_in & (sof ? accept : in_frame);

  // Each stage holds {keep, data}; the output stage lines up with the end of the SFD.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) dline[i] <= '0;
    end else begin
      dline[0] <= {keep_in, gmii_data_in};
      for (int i = 1; i < DEPTH; i++) dline[i] <= dline[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      dv_prev        <= 1'b1;
      in_frame       <= 1'b0;
      pre_cnt        <= '0;
      gap_cnt        <= '0;
      gmii_tx_en     <= 1'b0;
      gmii_txd       <= 8'h00;
      drop_pulse     <= 1'b0;
      frames_sent    <= '0;
      frames_dropped <= '0;
    end else begin
      dv_prev    <= gmii_dv_in;
      drop_pulse <= sof & ~accept;
      gmii_tx_en <= 1'b0;
      gmii_txd   <= 8'h00;

      if (sof) in_frame <= accept;
      else if (!gmii_dv_in) in_frame <= 1'b0;

      if (sof && !accept && frames_dropped != '1)
        frames_dropped <= frames_dropped + CNT_W'(1);

      case (state)
        IDLE: begin
          if (accept) begin
            state      <= PRE;
            pre_cnt    <= '0;
            gmii_tx_en <= 1'b1;
            gmii_txd   <= 8'h55;
            if (frames_sent != '1) frames_sent <= frames_sent + CNT_W'(1);
          end
        end
        PRE: begin
          gmii_tx_en <= 1'b1;
          if (pre_cnt == PRE_LAST) begin
            gmii_txd <= 8'hD5;
            state    <= DATA;
          end else begin
            gmii_txd <= 8'h55;
            pre_cnt  <= pre_cnt + 4'd1;
          end
        end
        DATA: begin
          if (dline[DEPTH-1][8]) begin
            gmii_tx_en <= 1'b1;
            gmii_txd   <= dline[DEPTH-1][7:0];
          end else begin
            // this idle cycle is the first of the gap
            state   <= (IFG_BYTES == 1) ? IDLE : GAP;
            gap_cnt <= 8'd1;
          end
        end
        GAP: begin
          if (gap_cnt >= GAP_LAST) state <= IDLE;
          else gap_cnt <= gap_cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_preamble_ifg.sv
// Randomised scoreboard bench for gmii_tx_preamble_ifg; a frame-level model predicts accept/drop
// and the exact output byte timeline, a monitor pops and compares whatever the DUT emits.
module tb_gmii_tx_preamble_ifg;
  localparam int P   = 7;
  localparam int IFG = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dv  = 1'b0;
  logic [7:0]  din = 8'h00;

  logic        gmii_tx_en, drop_pulse;
  logic [7:0]  gmii_txd;
  logic [15:0] frames_sent, frames_dropped;

  logic        s_tx_en, s_drop;
  logic [7:0]  s_txd;
  logic [3:0]  s_sent, s_dropped;

  gmii_tx_preamble_ifg #(.PREAMBLE_LEN(P), .IFG_BYTES(IFG), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .gmii_dv_in(dv), .gmii_data_in(din),
    .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd), .drop_pulse(drop_pulse),
    .frames_sent(frames_sent), .frames_dropped(frames_dropped));

  gmii_tx_preamble_ifg #(.PREAMBLE_LEN(P), .IFG_BYTES(IFG), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .gmii_dv_in(dv), .gmii_data_in(din),
    .gmii_tx_en(s_tx_en), .gmii_txd(s_txd), .drop_pulse(s_drop),
    .frames_sent(s_sent), .frames_dropped(s_dropped));

  typedef struct {int cyc; logic [7:0] d;} exp_t;
  exp_t exp_q[$];
  int   drop_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int sent_m = 0;
  int drop_m = 0;
  int last_end = -1000;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every output cycle is compared against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (gmii_tx_en === 1'b1) begin
      if (exp_q.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("tx_cycle", cyc, e.cyc);
        check("tx_byte", {24'd0, gmii_txd}, {24'd0, e.d});
      end
    end else begin
      check("idle_txd", {24'd0, gmii_txd}, 32'd0);
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        check("tx_en_missing", {31'd0, gmii_tx_en}, 32'd1);
        void'(exp_q.pop_front());
      end
    end
    if (drop_pulse === 1'b1) begin
      if (drop_q.size() == 0) check("drop_unexpected", 32'd1, 32'd0);
      else check("drop_cycle", cyc, drop_q.pop_front());
    end else if (drop_q.size() > 0 && drop_q[0] <= cyc) begin
      check("drop_missing", {31'd0, drop_pulse}, 32'd1);
      void'(drop_q.pop_front());
    end
  end

  task automatic step(input logic v, input logic [7:0] d);
    dv  = v;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    sent_m   = 0;
    drop_m   = 0;
    last_end = -1000;
  endtask

  // Model: a frame is accepted only if its start is at least P+IFG+2 edges after the
  // last byte of the previous accepted frame (i.e. P+IFG+1 idle input cycles).
  task automatic send_frame(input int gap, input int len, input int mode);
    logic [7:0] b;
    int s;
    bit acc;
    repeat (gap) step(1'b0, 8'h00);
    s   = cyc + 1;
    acc = (s - last_end) >= (P + IFG + 2);
    if (acc) begin
      for (int i = 0; i < P; i++) exp_q.push_back('{s + i, 8'h55});
      exp_q.push_back('{s + P, 8'hD5});
      sent_m++;
      last_end = s + len - 1;
    end else begin
      drop_q.push_back(s);
      drop_m++;
    end
    for (int j = 0; j < len; j++) begin
      b = (mode == 0) ? 8'(j) : (mode == 1) ? 8'($urandom) : 8'hA5;
      if (acc) exp_q.push_back('{s + P + 1 + j, b});
      step(1'b1, b);
    end
  endtask

  task automatic check_counters();
    check("frames_sent", {16'd0, frames_sent}, 32'(sent_m));
    check("frames_dropped", {16'd0, frames_dropped}, 32'(drop_m));
    check("small_sent", {28'd0, s_sent}, 32'((sent_m > 15) ? 15 : sent_m));
    check("small_dropped", {28'd0, s_dropped}, 32'((drop_m > 15) ? 15 : drop_m));
  endtask

  initial begin
    int r;
    logic [7:0] b;

    repeat (3) step(1'b0, 8'h00);
    check("rst_tx_en", {31'd0, gmii_tx_en}, 32'd0);
    check("rst_txd", {24'd0, gmii_txd}, 32'd0);
    check("rst_drop", {31'd0, drop_pulse}, 32'd0);
    check_counters();
    rst = 1'b0;

    // 64-byte incrementing frame whose first byte is sampled at edge 10
    send_frame(9 - cyc, 64, 0);
    send_frame(30, 1, 1);
    check_counters();

    // exactly the minimum spacing: both frames go out
    send_frame(40, 60, 1);
    send_frame(P + IFG + 1, 60, 1);
    check_counters();

    // one cycle short: second frame dropped, then a third frame after a full gap
    send_frame(40, 60, 1);
    send_frame(P + IFG, 60, 1);
    send_frame(P + IFG + 1, 50, 1);
    check_counters();

    // reset during the 30th data byte, with dv still high at release
    repeat (30) step(1'b0, 8'h00);
    begin
      int s;
      s = cyc + 1;
      for (int i = 0; i < P; i++) exp_q.push_back('{s + i, 8'h55});
      exp_q.push_back('{s + P, 8'hD5});
      for (int j = 0; j < 29; j++) begin
        b = 8'($urandom);
        exp_q.push_back('{s + P + 1 + j, b});
        step(1'b1, b);
      end
    end
    rst = 1'b1;
    r = cyc + 1;
    while (exp_q.size() > 0 && exp_q[$].cyc >= r) void'(exp_q.pop_back());
    while (drop_q.size() > 0 && drop_q[$] >= r) void'(drop_q.pop_back());
    model_reset();
    step(1'b1, 8'h33);
    check("rst_mid_tx_en", {31'd0, gmii_tx_en}, 32'd0);
    step(1'b1, 8'h34);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) step(1'b1, 8'(k));
    check_counters();
    send_frame(5, 20, 1);
    check_counters();

    // single-byte frame
    send_frame(25, 1, 2);
    check_counters();

    // sixteen back-to-back minimum-gap frames saturate the 4-bit counters
    for (int k = 0; k < 16; k++) send_frame(P + IFG + 1, $urandom_range(1, 8), 1);
    check_counters();

    // random spacing around the acceptance boundary
    for (int k = 0; k < 25; k++) send_frame($urandom_range(14, 26), $urandom_range(1, 40), 1);
    check_counters();

    repeat (40) step(1'b0, 8'h00);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("drop_q_empty", 32'(drop_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gmii_tx_preamble_ifg.md
Name: gmii_tx_preamble_ifg

Overview:
Downstream stage of the GMII CRC appender. It consumes frames that already carry their FCS and prefixes each one with a preamble and SFD: PREAMBLE_LEN bytes of 0x55, then one 0xD5. It enforces a minimum inter-frame gap on the output and drops whole input frames that arrive too close to the previous one. GMII has no backpressure, so the block uses a fixed-latency delay line and never stalls its input.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 bytes before the SFD (1..15)
IFG_BYTES, 12, minimum number of idle output cycles between two frames (1..255)
CNT_W, 16, width of the frame counters

Ports:
clk  input  1  clock, one GMII byte per cycle
rst  input  1  reset, synchronous, active-high
gmii_dv_in  input  1  valid from the CRC stage, high for the whole frame including FCS
gmii_data_in  input  8  byte from the CRC stage
gmii_tx_en  output  1  registered transmit enable to the PHY
gmii_txd  output  8  registered transmit byte to the PHY
drop_pulse  output  1  one-cycle pulse when an input frame is rejected
frames_sent  output  CNT_W  accepted-frame count, saturating
frames_dropped  output  CNT_W  rejected-frame count, saturating

Behaviour:
- Reset, and every output while rst is high: gmii_tx_en=0, gmii_txd=0x00, drop_pulse=0, both counters=0, state=IDLE, delay line cleared (keep flags 0).
- Internal dv_prev resets to 1. If gmii_dv_in is already high when reset releases, no rising edge is seen, so that frame is ignored silently and not counted.
- Start of frame: dv_in=1 while dv_prev=0, sampled at clock edge s.
- Accept rule: a start of frame is accepted only if state==IDLE at edge s. Accepted bytes go into the delay line with keep=1.
- Reject rule: otherwise every byte of that frame, up to the falling edge of dv_in, gets keep=0. drop_pulse=1 for the cycle after edge s, and frames_dropped increments.
- Delay line: PREAMBLE_LEN+1 stages, each holding {keep, data}.
- Latency: an input byte sampled at edge t is visible on gmii_txd at cycle t+PREAMBLE_LEN+2 (t+9 with defaults).
- State machine: IDLE -> PRE -> DATA -> GAP -> IDLE.
  - IDLE: tx_en=0, txd=0x00. An accepted start of frame moves to PRE, sets the preamble counter to 0 and increments frames_sent.
  - PRE: for PREAMBLE_LEN cycles, tx_en=1 and txd=0x55. The next cycle, tx_en=1 and txd=0xD5, then move to DATA. Visible timing with defaults: 0x55 in cycles s+1..s+7, 0xD5 in cycle s+8.
  - DATA: tx_en is the keep flag at the delay-line output; txd is that stage's data. The first cycle with keep=0 gives tx_en=0, txd=0x00, then move to GAP with the gap counter=1.
  - GAP: tx_en=0 and txd=0x00 for IFG_BYTES cycles in total, then IDLE.
- Minimum input spacing for acceptance: the number of idle dv_in cycles between frames must be at least IFG_BYTES+PREAMBLE_LEN+1 (20 with defaults).
  - Exactly 20: the output gap is exactly IFG_BYTES.
  - 19 or fewer: the second frame is dropped, the first is unaffected.
- A start of frame arriving during PRE, DATA or GAP is rejected. A dropped frame never produces tx_en=1 and never corrupts the frame in flight.
- A one-byte frame gives PRE, one DATA byte, then GAP.
- Counters saturate at all ones; neither counter wraps.
- txd is 0x00 whenever tx_en=0.
- Reset asserted mid-frame ends output immediately (tx_en=0 in the cycle after the reset edge). No partial frame resumes after reset.

Test Plan:
1. 64-byte frame, bytes 0x00..0x3F, starting at cycle 10 -> tx_en rises at 11; 0x55 in cycles 11..17, 0xD5 at 18, 0x00 at 19, 0x3F at 82; tx_en=0 at 83; frames_sent=1.
2. Two 60-byte frames with exactly 20 idle input cycles between them -> both transmitted; tx_en=0 for exactly 12 cycles between them; frames_sent=2, frames_dropped=0.
3. Same as scenario 2 but with a 19-cycle gap -> the second frame is absent on the output; drop_pulse is high for one cycle one cycle after its start; frames_dropped=1. The first frame is byte-exact.
4. Third frame sent 20 cycles after the dropped frame from scenario 3 ends -> accepted and transmitted normally.
5. rst asserted at the 30th data byte of a frame -> tx_en=0 on the next cycle. A frame with dv_in still high at reset release is ignored, with no counter change. The next clean frame is transmitted.
6. One-byte frame 0xA5 -> 7×0x55, 0xD5, 0xA5, then 12 idle cycles; frames_sent increments by 1.
7. With CNT_W=4, sixteen frames -> frames_sent stays at 0xF.
